// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, func3 size/sign encodings, misaligned-trap cause
// codes, byte-lane count and the natural-size lane mask helper.
package mem_pkg;

    localparam int MEM_BE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    // func3 load/store encodings; bit 2 selects zero extension on loads
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

    // Unshifted byte-enable mask for an access of 1 << sz bytes
    function automatic logic [MEM_BE_W-1:0] lane_mask(input logic [1:0] sz);
        logic [MEM_BE_W-1:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: shifts the returned doubleword down to the access offset,
// truncates to the access size and sign/zero-extends it.
// Latency: purely combinational. Backpressure: none.
// Ports: i_rdata raw bus data, i_off byte offset, i_func3 size/sign, o_data result.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [2:0]            i_off,
    input  logic [2:0]            i_func3,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_func3)
            F3_B:    o_data = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_H:    o_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   o_data = {{(DATA_WIDTH-8){1'b0}},  w_shifted[7:0]};
            F3_HU:   o_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            F3_WU:   o_data = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
            default: o_data = w_shifted;  // ld: offset is zero, pass whole doubleword
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: single-outstanding data-memory access stage; aligns store lanes,
// extracts/extends load data, passes write-back controls through.
// Latency: 2 stall cycles + DONE minimum; +1 stall per cycle of ready/rvalid delay.
// Backpressure: o_stall_mem holds upstream from start until DONE; dmem via req/ready.
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses (cause 4 load,
// 6 store) instead of rounding them down to natural alignment.
// Ports: i_clk/i_rst, instruction inputs (i_valid, i_alu_result, i_write_data,
// i_func3, i_mem_access, i_mem_we), write-back pass-through (reg_we, rd_addr,
// result_src, pc_plus4, alu_result), o_read_data, o_stall_mem, o_exception/o_cause,
// dmem request (o_dmem_req/we/addr/wdata/be, i_dmem_ready) and response
// (i_dmem_rvalid, i_dmem_rdata).
module memory_stage
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [2:0]            i_func3,
    input  logic                  i_mem_access,
    input  logic                  i_mem_we,
    input  logic                  i_reg_we,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_result_src,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    output logic                  o_reg_we,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [2:0]            o_result_src,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_stall_mem,
    output logic                  o_exception,
    output logic [3:0]            o_cause,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    output logic [MEM_BE_W-1:0]   o_dmem_be,
    input  logic                  i_dmem_ready,
    input  logic                  i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata
);

    mem_state_t            r_state;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [ADDR_WIDTH-1:0] r_dmem_addr;
    logic [DATA_WIDTH-1:0] r_dmem_wdata;
    logic [MEM_BE_W-1:0]   r_dmem_be;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [2:0]            r_off;
    logic [2:0]            r_func3;

    logic [1:0]            w_sz;
    logic [2:0]            w_addr_off;
    logic [2:0]            w_align_mask;
    logic [2:0]            w_off;
    logic                  w_misaligned;
    logic                  w_idle;
    logic                  w_start;
    logic [MEM_BE_W-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_sz       = i_func3[1:0];
    assign w_addr_off = i_alu_result[2:0];
    // size - 1 as a byte-offset mask: the offset bits that must be zero when aligned
    assign w_align_mask = (w_sz == 2'd0) ? 3'b000 :
                          (w_sz == 2'd1) ? 3'b001 :
                          (w_sz == 2'd2) ? 3'b011 : 3'b111;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = |(w_addr_off & w_align_mask);
    assign w_off        = w_addr_off;
`else
    // No trap: silently round the access down to its natural alignment
    assign w_misaligned = 1'b0;
    assign w_off        = w_addr_off & ~w_align_mask;
`endif

    assign w_idle  = (r_state == ST_IDLE);
    assign w_start = w_idle & i_valid & i_mem_access & ~w_misaligned;

    assign w_be    = MEM_BE_W'(lane_mask(w_sz) << w_off);
    assign w_wdata = i_write_data << {w_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    assign o_exception = ~i_rst & w_idle & i_valid & i_mem_access & w_misaligned;
    assign o_cause     = o_exception ? (i_mem_we ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN)
                                     : 4'd0;
`else
    assign o_exception = 1'b0;
    assign o_cause     = 4'd0;
`endif

    // Stall from the start cycle through REQ/RESP; DONE releases the pipeline
    assign o_stall_mem = ~i_rst & (w_start | (r_state == ST_REQ) | (r_state == ST_RESP));

    assign o_reg_we     = i_reg_we & ~o_exception;
    assign o_rd_addr    = i_rd_addr;
    assign o_result_src = i_result_src;
    assign o_pc_plus4   = i_pc_plus4;
    assign o_alu_result = i_alu_result;

    assign o_read_data  = r_read_data;
    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_dmem_be    = r_dmem_be;

    mem_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .i_rdata (i_dmem_rdata),
        .i_off   (r_off),
        .i_func3 (r_func3),
        .o_data  (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= '0;
            r_read_data  <= '0;
            r_off        <= '0;
            r_func3      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= i_mem_we;
                        r_dmem_addr  <= {i_alu_result[ADDR_WIDTH-1:3], 3'b000};
                        r_dmem_wdata <= w_wdata;
                        r_dmem_be    <= w_be;
                        r_off        <= w_off;
                        r_func3      <= i_func3;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // rvalid without ready cannot belong to this request; ignore it
                    if (i_dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_state <= ST_DONE;
                        end else if (i_dmem_rvalid) begin
                            r_read_data <= w_load_data;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_dmem_rvalid) begin
                        r_read_data <= w_load_data;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of memory_stage load/store sequencing,
// byte-lane generation, load extension, reset recovery and back-to-back issue.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_memory_stage;
    import mem_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [63:0] i_alu_result;
    logic [63:0] i_write_data;
    logic [2:0]  i_func3;
    logic        i_mem_access;
    logic        i_mem_we;
    logic        i_reg_we;
    logic [4:0]  i_rd_addr;
    logic [2:0]  i_result_src;
    logic [63:0] i_pc_plus4;
    logic        o_reg_we;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic [63:0] o_pc_plus4;
    logic [63:0] o_alu_result;
    logic [63:0] o_read_data;
    logic        o_stall_mem;
    logic        o_exception;
    logic [3:0]  o_cause;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [63:0] o_dmem_addr;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [63:0] i_dmem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    memory_stage #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .REG_ADDR_W (5)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .i_alu_result  (i_alu_result),
        .i_write_data  (i_write_data),
        .i_func3       (i_func3),
        .i_mem_access  (i_mem_access),
        .i_mem_we      (i_mem_we),
        .i_reg_we      (i_reg_we),
        .i_rd_addr     (i_rd_addr),
        .i_result_src  (i_result_src),
        .i_pc_plus4    (i_pc_plus4),
        .o_reg_we      (o_reg_we),
        .o_rd_addr     (o_rd_addr),
        .o_result_src  (o_result_src),
        .o_pc_plus4    (o_pc_plus4),
        .o_alu_result  (o_alu_result),
        .o_read_data   (o_read_data),
        .o_stall_mem   (o_stall_mem),
        .o_exception   (o_exception),
        .o_cause       (o_cause),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_be     (o_dmem_be),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic set_op(input logic we, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd);
        i_valid      = 1'b1;
        i_mem_access = 1'b1;
        i_mem_we     = we;
        i_func3      = f3;
        i_alu_result = addr;
        i_write_data = wd;
    endtask

    task automatic clear_op();
        i_valid      = 1'b0;
        i_mem_access = 1'b0;
        i_mem_we     = 1'b0;
    endtask

    initial begin
        // Reset with a memory instruction already presented: nothing may start
        i_rst = 1'b1;
        i_reg_we = 1'b1; i_rd_addr = 5'd7; i_result_src = 3'd1; i_pc_plus4 = 64'h400;
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        set_op(1'b0, F3_W, 64'h1004, 64'h0);
        repeat (2) @(posedge i_clk);
        mid();
        check("rst_stall", {63'd0, o_stall_mem}, 64'd0);
        check("rst_req",   {63'd0, o_dmem_req},  64'd0);
        check("rst_we",    {63'd0, o_dmem_we},   64'd0);
        check("rst_be",    {56'd0, o_dmem_be},   64'd0);
        check("rst_addr",  o_dmem_addr,          64'd0);
        check("rst_wdata", o_dmem_wdata,         64'd0);
        check("rst_rdata", o_read_data,          64'd0);
        check("rst_exc",   {63'd0, o_exception}, 64'd0);
        check("rst_cause", {60'd0, o_cause},     64'd0);

        // lw 0x1004, ready+rvalid together: 2 stall cycles then DONE
        step();
        i_rst = 1'b0;
        mid();
        check("lw_idle_stall", {63'd0, o_stall_mem}, 64'd1);
        check("lw_idle_req",   {63'd0, o_dmem_req},  64'd0);
        check("pt_rd",         {59'd0, o_rd_addr},   64'd7);
        check("pt_pc",         o_pc_plus4,           64'h400);
        check("pt_alu",        o_alu_result,         64'h1004);
        check("pt_src",        {61'd0, o_result_src}, 64'd1);
        check("pt_regwe",      {63'd0, o_reg_we},    64'd1);
        step();
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h8000_0000_0000_0000;
        mid();
        check("lw_req",       {63'd0, o_dmem_req},  64'd1);
        check("lw_be",        {56'd0, o_dmem_be},   64'hF0);
        check("lw_addr",      o_dmem_addr,          64'h1000);
        check("lw_we",        {63'd0, o_dmem_we},   64'd0);
        check("lw_req_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        mid();
        check("lw_done_stall", {63'd0, o_stall_mem}, 64'd0);
        check("lw_done_req",   {63'd0, o_dmem_req},  64'd0);
        check("lw_rdata",      o_read_data,          64'hFFFF_FFFF_8000_0000);
        step();
        clear_op();
        mid();
        check("lw_after_stall", {63'd0, o_stall_mem}, 64'd0);
        check("lw_rdata_hold",  o_read_data,          64'hFFFF_FFFF_8000_0000);

        // sb 0x1003, ready delayed 3 cycles: request held 4 cycles
        step();
        set_op(1'b1, F3_B, 64'h1003, 64'h0000_0000_0000_00AB);
        mid();
        check("sb_idle_stall", {63'd0, o_stall_mem}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            mid();
            check("sb_wait_req",   {63'd0, o_dmem_req},  64'd1);
            check("sb_wait_stall", {63'd0, o_stall_mem}, 64'd1);
        end
        step();
        i_dmem_ready = 1'b1;
        mid();
        check("sb_req",   {63'd0, o_dmem_req}, 64'd1);
        check("sb_we",    {63'd0, o_dmem_we},  64'd1);
        check("sb_be",    {56'd0, o_dmem_be},  64'h08);
        check("sb_wdata", o_dmem_wdata,        64'h0000_0000_AB00_0000);
        step();
        i_dmem_ready = 1'b0;
        mid();
        check("sb_done_stall", {63'd0, o_stall_mem}, 64'd0);
        check("sb_done_req",   {63'd0, o_dmem_req},  64'd0);
        check("sb_rdata_kept", o_read_data,          64'hFFFF_FFFF_8000_0000);
        step();
        clear_op();
        mid();
        check("sb_idle_req", {63'd0, o_dmem_req}, 64'd0);

        // lhu 0x2006, rvalid 5 cycles after ready
        step();
        set_op(1'b0, F3_HU, 64'h2006, 64'h0);
        mid();
        check("lhu_idle_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_dmem_ready = 1'b1;
        mid();
        check("lhu_req",  {63'd0, o_dmem_req}, 64'd1);
        check("lhu_be",   {56'd0, o_dmem_be},  64'hC0);
        check("lhu_addr", o_dmem_addr,         64'h2000);
        for (int k = 1; k <= 4; k++) begin
            step();
            i_dmem_ready = 1'b0;
            i_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            mid();
            check("lhu_resp_stall", {63'd0, o_stall_mem}, 64'd1);
            check("lhu_resp_req",   {63'd0, o_dmem_req},  64'd0);
        end
        step();
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hBEEF_0000_0000_0000;
        mid();
        check("lhu_rv_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        mid();
        check("lhu_done_stall", {63'd0, o_stall_mem}, 64'd0);
        check("lhu_rdata",      o_read_data,          64'h0000_0000_0000_BEEF);
        step();
        clear_op();
        mid();

        // misaligned lw 0x1002
        step();
        set_op(1'b0, F3_W, 64'h1002, 64'h0);
        mid();
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_exc",   {63'd0, o_exception}, 64'd1);
        check("mis_cause", {60'd0, o_cause},     64'd4);
        check("mis_regwe", {63'd0, o_reg_we},    64'd0);
        check("mis_stall", {63'd0, o_stall_mem}, 64'd0);
        step();
        clear_op();
        mid();
        check("mis_noreq", {63'd0, o_dmem_req},  64'd0);
`else
        check("mis_exc",   {63'd0, o_exception}, 64'd0);
        check("mis_cause", {60'd0, o_cause},     64'd0);
        check("mis_regwe", {63'd0, o_reg_we},    64'd1);
        check("mis_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h1234_5678_DEAD_BEEF;
        mid();
        check("mis_req",  {63'd0, o_dmem_req}, 64'd1);
        check("mis_addr", o_dmem_addr,         64'h1000);
        check("mis_be",   {56'd0, o_dmem_be},  64'h0F);
        step();
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        mid();
        check("mis_rdata", o_read_data, 64'hFFFF_FFFF_DEAD_BEEF);
        step();
        clear_op();
        mid();
`endif

        // reset while waiting in RESP, then a late rvalid right after reset
        step();
        set_op(1'b0, F3_W, 64'h1004, 64'h0);
        mid();
        check("rr_idle_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_dmem_ready = 1'b1;
        mid();
        check("rr_req", {63'd0, o_dmem_req}, 64'd1);
        step();
        i_dmem_ready = 1'b0;
        mid();
        check("rr_resp_stall", {63'd0, o_stall_mem}, 64'd1);
        step();
        i_rst = 1'b1;
        mid();
        check("rr_rst_stall", {63'd0, o_stall_mem}, 64'd0);
        step();
        i_rst = 1'b0;
        clear_op();
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
        mid();
        check("rr_req_low",  {63'd0, o_dmem_req},  64'd0);
        check("rr_stall",    {63'd0, o_stall_mem}, 64'd0);
        check("rr_rdata",    o_read_data,          64'd0);
        step();
        i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        mid();
        check("rr_rdata_ignored", o_read_data, 64'd0);

        // back-to-back sd then ld with no gap
        step();
        set_op(1'b1, F3_D, 64'h3000, 64'h1122_3344_5566_7788);
        mid();
        check("sd_idle_stall", {63'd0, o_stall_mem}, 64'd1);
        check("sd_idle_req",   {63'd0, o_dmem_req},  64'd0);
        step();
        i_dmem_ready = 1'b1;
        mid();
        check("sd_req",   {63'd0, o_dmem_req}, 64'd1);
        check("sd_be",    {56'd0, o_dmem_be},  64'hFF);
        check("sd_wdata", o_dmem_wdata,        64'h1122_3344_5566_7788);
        check("sd_addr",  o_dmem_addr,         64'h3000);
        step();
        i_dmem_ready = 1'b0;
        mid();
        check("sd_done_stall", {63'd0, o_stall_mem}, 64'd0);
        step();
        set_op(1'b0, F3_D, 64'h3008, 64'h0);
        mid();
        check("ld_issue_stall", {63'd0, o_stall_mem}, 64'd1);
        check("ld_issue_req",   {63'd0, o_dmem_req},  64'd0);
        step();
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'h0102_0304_0506_0708;
        mid();
        check("ld_req",  {63'd0, o_dmem_req}, 64'd1);
        check("ld_addr", o_dmem_addr,         64'h3008);
        check("ld_we",   {63'd0, o_dmem_we},  64'd0);
        check("ld_be",   {56'd0, o_dmem_be},  64'hFF);
        step();
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 64'h0;
        mid();
        check("ld_done_stall", {63'd0, o_stall_mem}, 64'd0);
        check("ld_rdata",      o_read_data,          64'h0102_0304_0506_0708);
        step();
        clear_op();
        mid();
        check("ld_after_req", {63'd0, o_dmem_req}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
